// File: rtl/candy_exec_if.sv
// rtl/candy_exec_if.sv - decode handshake and register-file write port bundle for candy_exec
interface candy_exec_if #(
   parameter int WIDTH = 24,
   parameter int RADDR = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [RADDR-1:0] rd;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             write_enable;
   logic [RADDR-1:0] waddr;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             zero;
   logic             carry;

   modport master (
      output in_valid, op, rd, a, b,
      input  in_ready, write_enable, waddr, wdata, busy, zero, carry
   );

   modport slave (
      input  in_valid, op, rd, a, b,
      output in_ready, write_enable, waddr, wdata, busy, zero, carry
   );
endinterface

// File: rtl/candy_exec.sv
// rtl/candy_exec.sv - candy 24-bit execute/writeback stage: single-cycle ALU plus iterative multiply
module candy_exec #(
   parameter int WIDTH = 24,
   parameter int RADDR = 4
) (
   input  logic         clk,
   input  logic         reset,
   candy_exec_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t           r_state, w_state_next;
   logic             w_accept;
   logic             w_last_iter;
   logic [4:0]       w_shamt;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [WIDTH-1:0] w_alu;
   logic             w_alu_wr, w_alu_flag, w_alu_carry;
   logic [WIDTH-1:0] w_acc_next;

   logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
   logic [CW-1:0]    r_cnt;
   logic [RADDR-1:0] r_mul_rd;
   logic             r_we;
   logic [RADDR-1:0] r_waddr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_zero, r_carry;

   assign w_accept    = bus.in_valid && (r_state == S_IDLE);
   assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
   assign w_shamt     = bus.b[4:0];
   assign w_sum       = {1'b0, bus.a} + {1'b0, bus.b};
   // Top bit of the extended difference is the borrow; carry is its inverse.
   assign w_diff      = {1'b0, bus.a} - {1'b0, bus.b};
   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_comb begin
      w_alu       = '0;
      w_alu_wr    = 1'b1;
      w_alu_flag  = 1'b0;
      w_alu_carry = 1'b0;
      case (bus.op)
         4'd0: begin
            w_alu       = w_sum[WIDTH-1:0];
            w_alu_flag  = 1'b1;
            w_alu_carry = w_sum[WIDTH];
         end
         4'd1: begin
            w_alu       = w_diff[WIDTH-1:0];
            w_alu_flag  = 1'b1;
            w_alu_carry = ~w_diff[WIDTH];
         end
         4'd2: w_alu = bus.a & bus.b;
         4'd3: w_alu = bus.a | bus.b;
         4'd4: w_alu = bus.a ^ bus.b;
         4'd5: w_alu = (w_shamt >= 5'(WIDTH)) ? '0 : (bus.a << w_shamt);
         4'd6: w_alu = (w_shamt >= 5'(WIDTH)) ? '0 : (bus.a >> w_shamt);
         4'd7: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         4'd9: w_alu = bus.b;
         default: w_alu_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept && (bus.op == 4'd8)) w_state_next = S_MUL;
         S_MUL:  if (w_last_iter) w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_mul_rd <= '0;
      end else begin
         r_we <= 1'b0;
         if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last_iter) begin
               r_we    <= 1'b1;
               r_waddr <= r_mul_rd;
               r_wdata <= w_acc_next;
               r_zero  <= (w_acc_next == '0);
            end
         end else if (w_accept) begin
            if (bus.op == 4'd8) begin
               r_mcand  <= bus.a;
               r_mplier <= bus.b;
               r_acc    <= '0;
               r_cnt    <= '0;
               r_mul_rd <= bus.rd;
            end else if (w_alu_wr) begin
               r_we    <= 1'b1;
               r_waddr <= bus.rd;
               r_wdata <= w_alu;
               r_zero  <= (w_alu == '0);
               if (w_alu_flag) r_carry <= w_alu_carry;
            end
         end
      end
   end

   assign bus.in_ready     = (r_state == S_IDLE);
   assign bus.busy         = (r_state == S_MUL);
   assign bus.write_enable = r_we;
   assign bus.waddr        = r_waddr;
   assign bus.wdata        = r_wdata;
   assign bus.zero         = r_zero;
   assign bus.carry        = r_carry;
endmodule

// File: tb/tb_candy_exec.sv
// tb/tb_candy_exec.sv - self-checking bench for candy_exec with a queue-based reference model
module tb_candy_exec;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   candy_exec_if #(.WIDTH(24), .RADDR(4)) bus ();

   candy_exec #(.WIDTH(24), .RADDR(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [3:0] addr;
      longint     data;
      bit         addsub;
      bit         c;
   } wr_t;

   wr_t        q[$];
   int         m_n;
   bit         m_init;
   int         m_busy;
   logic [3:0] m_waddr;
   longint     m_wdata;
   bit         m_zero;
   bit         m_carry;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void ref_op(input int op, input longint a, input longint b,
                                  output longint r, output bit c, output bit addsub, output bit wr);
      longint sa, sb;
      int sh;
      r = 0; c = 0; addsub = 0; wr = 1;
      sh = int'(b % 32);
      sa = (a >= 64'h800000) ? a - 64'h1000000 : a;
      sb = (b >= 64'h800000) ? b - 64'h1000000 : b;
      case (op)
         0: begin r = a + b; c = (r >= 64'h1000000); addsub = 1; end
         1: begin r = a - b; c = (a >= b); addsub = 1; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (sh >= 24) ? 0 : (a << sh);
         6: r = (sh >= 24) ? 0 : (a >> sh);
         7: r = (sa < sb) ? 1 : 0;
         8: r = a * b;
         9: r = b;
         default: wr = 0;
      endcase
      r = r & 64'hFFFFFF;
   endfunction

   // Called once per cycle at the falling edge: compare, then consume the presented inputs.
   task automatic model_cycle();
      bit     exp_we, exp_ready, c, addsub, wr;
      longint r;
      wr_t    e;
      exp_ready = (m_busy == 0);
      if (m_init) begin
         exp_we = (q.size() > 0) && (q[0].due == m_n);
         if (exp_we) begin
            e = q.pop_front();
            m_waddr = e.addr;
            m_wdata = e.data;
            m_zero  = (e.data == 0);
            if (e.addsub) m_carry = e.c;
         end
         chk("m_write_enable", 32'(bus.write_enable), 32'(exp_we));
         chk("m_waddr", 32'(bus.waddr), 32'(m_waddr));
         chk("m_wdata", 32'(bus.wdata), 32'(m_wdata));
         chk("m_in_ready", 32'(bus.in_ready), 32'(exp_ready));
         chk("m_busy", 32'(bus.busy), 32'(!exp_ready));
         chk("m_zero", 32'(bus.zero), 32'(m_zero));
         chk("m_carry", 32'(bus.carry), 32'(m_carry));
      end
      if (reset) begin
         m_init = 1; q.delete(); m_busy = 0;
         m_waddr = 0; m_wdata = 0; m_zero = 0; m_carry = 0;
      end else if (m_init) begin
         if (m_busy > 0) m_busy--;
         if (bus.in_valid && exp_ready) begin
            ref_op(int'(bus.op), longint'(bus.a), longint'(bus.b), r, c, addsub, wr);
            if (bus.op == 4'd8) begin
               q.push_back('{due: m_n + 25, addr: bus.rd, data: r, addsub: 0, c: 0});
               m_busy = 24;
            end else if (wr) begin
               q.push_back('{due: m_n + 1, addr: bus.rd, data: r, addsub: addsub, c: c});
            end
         end
      end
      m_n++;
   endtask

   task automatic clk1();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [3:0] op, input logic [3:0] rd, input logic [23:0] a, input logic [23:0] b);
      bus.in_valid = 1'b1; bus.op = op; bus.rd = rd; bus.a = a; bus.b = b;
      clk1();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int pulses;
      checks = 0; errors = 0;
      m_n = 0; m_init = 0; m_busy = 0; m_waddr = 0; m_wdata = 0; m_zero = 0; m_carry = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.rd = '0; bus.a = '0; bus.b = '0;
      repeat (3) clk1();
      reset = 1'b0;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", 32'(bus.write_enable), 32'd0);
      chk("rst_wdata", 32'(bus.wdata), 32'd0);
      chk("rst_flags", {30'd0, bus.zero, bus.carry}, 32'd0);

      send1(4'd0, 4'd3, 24'hFFFFFF, 24'h000001);
      chk("add_we", 32'(bus.write_enable), 32'd1);
      chk("add_waddr", 32'(bus.waddr), 32'd3);
      chk("add_wdata", 32'(bus.wdata), 32'h000000);
      chk("add_zero", 32'(bus.zero), 32'd1);
      chk("add_carry", 32'(bus.carry), 32'd1);
      clk1();

      bus.in_valid = 1'b1; bus.op = 4'd1; bus.rd = 4'd1; bus.a = 24'd5; bus.b = 24'd7;
      clk1();
      bus.op = 4'd7; bus.rd = 4'd2; bus.a = 24'h800000; bus.b = 24'd1;
      chk("sub_we", 32'(bus.write_enable), 32'd1);
      chk("sub_wdata", 32'(bus.wdata), 32'hFFFFFE);
      chk("sub_carry", 32'(bus.carry), 32'd0);
      clk1();
      bus.in_valid = 1'b0;
      chk("slt_we", 32'(bus.write_enable), 32'd1);
      chk("slt_waddr", 32'(bus.waddr), 32'd2);
      chk("slt_wdata", 32'(bus.wdata), 32'h000001);
      clk1();

      send1(4'd5, 4'd4, 24'h000001, 24'd23);
      chk("shl23", 32'(bus.wdata), 32'h800000);
      send1(4'd5, 4'd4, 24'h000001, 24'd24);
      chk("shl24", 32'(bus.wdata), 32'h000000);
      send1(4'd6, 4'd5, 24'h800000, 24'd31);
      chk("shr31", 32'(bus.wdata), 32'h000000);
      send1(4'd4, 4'd6, 24'hF0F0F0, 24'hFF00FF);
      chk("xor", 32'(bus.wdata), 32'h0FF00F);
      send1(4'd9, 4'd0, 24'h123456, 24'hABCDEF);
      chk("movb", 32'(bus.wdata), 32'hABCDEF);
      chk("movb_waddr", 32'(bus.waddr), 32'd0);
      clk1();

      send1(4'd8, 4'd7, 24'h001234, 24'h000100);
      for (int i = 1; i <= 24; i++) begin
         chk("mul_busy", 32'(bus.busy), 32'd1);
         chk("mul_in_ready", 32'(bus.in_ready), 32'd0);
         chk("mul_no_we", 32'(bus.write_enable), 32'd0);
         bus.in_valid = (i <= 22); bus.op = 4'd0; bus.rd = 4'd5; bus.a = 24'd1; bus.b = 24'd1;
         clk1();
      end
      chk("mul_we", 32'(bus.write_enable), 32'd1);
      chk("mul_waddr", 32'(bus.waddr), 32'd7);
      chk("mul_wdata", 32'(bus.wdata), 32'h123400);
      chk("mul_ready_back", 32'(bus.in_ready), 32'd1);
      clk1();
      chk("mul_single_pulse", 32'(bus.write_enable), 32'd0);

      send1(4'd8, 4'd8, 24'hFFFFFF, 24'hFFFFFF);
      repeat (24) clk1();
      chk("mul2_we", 32'(bus.write_enable), 32'd1);
      chk("mul2_wdata", 32'(bus.wdata), 32'h000001);
      clk1();

      send1(4'd8, 4'd9, 24'd3, 24'd5);
      repeat (9) clk1();
      reset = 1'b1;
      clk1();
      reset = 1'b0;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_wdata", 32'(bus.wdata), 32'd0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.write_enable) pulses++;
         clk1();
      end
      chk("abort_no_write", 32'(pulses), 32'd0);

      send1(4'd0, 4'd4, 24'hFFFFFF, 24'h000002);
      chk("pre_nop_wdata", 32'(bus.wdata), 32'h000001);
      chk("pre_nop_carry", 32'(bus.carry), 32'd1);
      bus.in_valid = 1'b1; bus.op = 4'd12; bus.rd = 4'd4; bus.a = 24'd0; bus.b = 24'd0;
      chk("nop_in_ready", 32'(bus.in_ready), 32'd1);
      clk1();
      bus.in_valid = 1'b0;
      chk("nop_we", 32'(bus.write_enable), 32'd0);
      chk("nop_flags", {30'd0, bus.zero, bus.carry}, 32'd1);
      chk("nop_wdata_hold", 32'(bus.wdata), 32'h000001);
      chk("nop_ready", 32'(bus.in_ready), 32'd1);
      repeat (3) clk1();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
